// File: rtl/sap3_ext_mem_arbiter.sv
// Round-robin arbiter sharing the SAP-3 external memory pads between the CPU (A)
// and the loader (B); each transaction runs ADDR_LO, optional ADDR_HI, DATA, ACK.
module sap3_ext_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          HI_SKIP     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic [7:0]  pad_out,
  output logic        pad_oe,
  input  logic [7:0]  pad_in,
  output logic        pad_ale_lo,
  output logic        pad_ale_hi,
  output logic        pad_we,
  output logic        pad_re,
  output logic        busy,
  output logic        grant_b
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_DATA,
    S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        last_b_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [3:0]  cnt_q;
  logic [7:0]  cache_q;
  logic        cache_vld_q;

  logic        grant, to_b, skip;
  logic        eff_b, eff_we;
  logic [15:0] eff_addr;
  logic [7:0]  eff_wdata;
  logic [7:0]  pad_out_d;
  logic        pad_oe_d, ale_lo_d, ale_hi_d, pad_we_d, pad_re_d, a_ack_d, b_ack_d;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    to_b    = 1'b0;
    skip    = HI_SKIP && cache_vld_q && (addr_q[15:8] == cache_q);
    unique case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          grant   = 1'b1;
          to_b    = b_req && !(a_req && last_b_q);
          state_d = S_ADDR_LO;
        end
      end
      S_ADDR_LO: state_d = skip ? S_DATA : S_ADDR_HI;
      S_ADDR_HI: state_d = S_DATA;
      S_DATA:    if (cnt_q == 4'(WAIT_CYCLES)) state_d = S_ACK;
      S_ACK:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Outputs are registered, so decode from the next state; on the grant edge the
    // transaction fields come straight from the winning port.
    eff_b     = grant ? to_b : grant_b;
    eff_we    = grant ? (to_b ? b_we : a_we) : we_q;
    eff_addr  = grant ? (to_b ? b_addr : a_addr) : addr_q;
    eff_wdata = grant ? (to_b ? b_wdata : a_wdata) : wdata_q;

    pad_out_d = '0;
    pad_oe_d  = 1'b0;
    ale_lo_d  = 1'b0;
    ale_hi_d  = 1'b0;
    pad_we_d  = 1'b0;
    pad_re_d  = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    unique case (state_d)
      S_ADDR_LO: begin
        pad_out_d = eff_addr[7:0];
        pad_oe_d  = 1'b1;
        ale_lo_d  = 1'b1;
      end
      S_ADDR_HI: begin
        pad_out_d = eff_addr[15:8];
        pad_oe_d  = 1'b1;
        ale_hi_d  = 1'b1;
      end
      S_DATA: begin
        if (eff_we) begin
          pad_out_d = eff_wdata;
          pad_oe_d  = 1'b1;
          pad_we_d  = 1'b1;
        end else begin
          pad_re_d  = 1'b1;
        end
      end
      S_ACK: begin
        a_ack_d = !eff_b;
        b_ack_d = eff_b;
        if (eff_we) begin
          pad_out_d = eff_wdata;
          pad_oe_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_b_q    <= 1'b1;
      grant_b     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      pad_out     <= '0;
      pad_oe      <= 1'b0;
      pad_ale_lo  <= 1'b0;
      pad_ale_hi  <= 1'b0;
      pad_we      <= 1'b0;
      pad_re      <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        grant_b  <= to_b;
        last_b_q <= to_b;
        we_q     <= eff_we;
        addr_q   <= eff_addr;
        wdata_q  <= eff_wdata;
      end
      cnt_q <= (state_q == S_DATA && state_d == S_DATA) ? cnt_q + 4'd1 : '0;
      if (state_d == S_ADDR_HI) begin
        cache_q     <= addr_q[15:8];
        cache_vld_q <= 1'b1;
      end
      if (state_q == S_DATA && state_d == S_ACK && !we_q) begin
        if (grant_b) b_rdata <= pad_in;
        else         a_rdata <= pad_in;
      end
      pad_out    <= pad_out_d;
      pad_oe     <= pad_oe_d;
      pad_ale_lo <= ale_lo_d;
      pad_ale_hi <= ale_hi_d;
      pad_we     <= pad_we_d;
      pad_re     <= pad_re_d;
      a_ack      <= a_ack_d;
      b_ack      <= b_ack_d;
      busy       <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sap3_ext_mem_arbiter.sv
// Directed bench for sap3_ext_mem_arbiter: three builds (WAIT_CYCLES 1, 0, 15) with
// a per-cycle pad model and an ack scoreboard on the WAIT_CYCLES=1 build.
module tb_sap3_ext_mem_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]       a_req, a_we, b_req, b_we;
  logic [N-1:0][15:0] a_addr, b_addr;
  logic [N-1:0][7:0]  a_wdata, b_wdata, pad_in;
  logic [N-1:0]       a_ack, b_ack, pad_oe, pad_ale_lo, pad_ale_hi, pad_we, pad_re, busy, grant_b;
  logic [N-1:0][7:0]  a_rdata, b_rdata, pad_out;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned WC = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    sap3_ext_mem_arbiter #(.WAIT_CYCLES(WC), .HI_SKIP(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req[g]), .a_we(a_we[g]), .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
      .a_ack(a_ack[g]), .a_rdata(a_rdata[g]),
      .b_req(b_req[g]), .b_we(b_we[g]), .b_addr(b_addr[g]), .b_wdata(b_wdata[g]),
      .b_ack(b_ack[g]), .b_rdata(b_rdata[g]),
      .pad_out(pad_out[g]), .pad_oe(pad_oe[g]), .pad_in(pad_in[g]),
      .pad_ale_lo(pad_ale_lo[g]), .pad_ale_hi(pad_ale_hi[g]),
      .pad_we(pad_we[g]), .pad_re(pad_re[g]), .busy(busy[g]), .grant_b(grant_b[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int w_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
  endfunction

  // Scoreboard of acks expected from build 0, in order.
  typedef struct packed {
    logic       b;
    logic       we;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];
  int   ack_seen = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      check("dual_ack", 32'(a_ack[0] & b_ack[0]), 32'd0);
      check("we_re_overlap", 32'(pad_we[0] & pad_re[0]), 32'd0);
      if (a_ack[0] || b_ack[0]) begin
        ack_seen++;
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'({b_ack[0], a_ack[0]}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_port", 32'({b_ack[0], a_ack[0]}), e.b ? 32'd2 : 32'd1);
          check("ack_grant_b", 32'(grant_b[0]), 32'(e.b));
          if (!e.we) check("ack_rdata", 32'(e.b ? b_rdata[0] : a_rdata[0]), 32'(e.rdata));
        end
      end
    end
  end

  logic [7:0] mc[N];
  bit         mv[N];

  task automatic reset_models();
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    reset_models();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One transaction on build d, checked cycle by cycle against the pad protocol.
  task automatic run_txn(input int d, input bit b, input bit we, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] pin);
    int   w      = w_of(d);
    bit   skip   = mv[d] && (mc[d] == addr[15:8]);
    int   ack_k  = (skip ? 3 : 4) + w;
    int   we_cnt = 0;
    int   ack_at = -1;
    bit   lo, hi, data, ack, idle, e_oe;
    logic [7:0] e_out, e_flags, obs;
    if (!skip) begin
      mc[d] = addr[15:8];
      mv[d] = 1'b1;
    end
    pad_in[d] = pin;
    if (b) begin
      b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = addr; b_wdata[d] = wd;
    end else begin
      a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wd;
    end
    if (d == 0) sb.push_back(exp_t'{b: b, we: we, rdata: pin});
    @(posedge clk);
    for (int k = 1; k <= ack_k + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Fields must have been latched at the grant edge.
        if (b) begin b_we[d] = ~we; b_addr[d] = ~addr; b_wdata[d] = ~wd; end
        else   begin a_we[d] = ~we; a_addr[d] = ~addr; a_wdata[d] = ~wd; end
      end
      lo    = (k == 1);
      hi    = !skip && (k == 2);
      data  = (k >= (skip ? 2 : 3)) && (k < ack_k);
      ack   = (k == ack_k);
      idle  = (k > ack_k);
      e_oe  = lo || hi || (we && (data || ack));
      e_out = lo ? addr[7:0] : (hi ? addr[15:8] : wd);
      e_flags = {!idle, e_oe, lo, hi, we && data, !we && data, ack && !b, ack && b};
      obs = {busy[d], pad_oe[d], pad_ale_lo[d], pad_ale_hi[d], pad_we[d], pad_re[d],
             a_ack[d], b_ack[d]};
      check($sformatf("d%0d_%04h_k%0d_flags", d, addr, k), 32'(obs), 32'(e_flags));
      if (e_oe) check($sformatf("d%0d_%04h_k%0d_pad_out", d, addr, k), 32'(pad_out[d]), 32'(e_out));
      if (pad_we[d]) we_cnt++;
      if (a_ack[d] || b_ack[d]) begin
        ack_at = k;
        a_req[d] = 1'b0;
        b_req[d] = 1'b0;
      end
    end
    a_req[d] = 1'b0;
    b_req[d] = 1'b0;
    if (we) check($sformatf("d%0d_%04h_we_width", d, addr), 32'(we_cnt), 32'(w + 1));
    check($sformatf("d%0d_%04h_ack_cycle", d, addr), 32'(ack_at), 32'(ack_k));
    if (d != 0 && !we) check($sformatf("d%0d_%04h_rdata", d, addr), 32'(a_rdata[d]), 32'(pin));
  endtask

  initial begin
    int ack_base;
    rst_n = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    pad_in = '0;
    reset_models();
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check($sformatf("d%0d_reset_ctrl", d),
            32'({busy[d], pad_oe[d], pad_ale_lo[d], pad_ale_hi[d], pad_we[d], pad_re[d],
                 a_ack[d], b_ack[d], grant_b[d]}), 32'd0);
      check($sformatf("d%0d_reset_data", d), 32'({pad_out[d], a_rdata[d], b_rdata[d]}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Loader reads with differing high bytes; CPU read data untouched.
    run_txn(0, 1'b1, 1'b0, 16'hFF00, 8'h00, 8'h11);
    run_txn(0, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h22);
    check("b_rdata_hold", 32'(b_rdata[0]), 32'h22);
    check("a_rdata_untouched", 32'(a_rdata[0]), 32'h00);

    // CPU write then read in the same 256-byte page (second skips ADDR_HI).
    run_txn(0, 1'b0, 1'b1, 16'h1234, 8'hAB, 8'h00);
    run_txn(0, 1'b0, 1'b0, 16'h1250, 8'h00, 8'h5C);
    check("a_rdata_hold", 32'(a_rdata[0]), 32'h5C);
    check("b_rdata_untouched", 32'(b_rdata[0]), 32'h22);

    // Both requesting from reset: grants alternate starting with A.
    rst_n = 1'b0;
    reset_models();
    a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 16'h4010;
    b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = 16'h4020;
    pad_in[0] = 8'h77;
    for (int i = 0; i < 4; i++) sb.push_back(exp_t'{b: (i % 2 == 1), we: 1'b0, rdata: 8'h77});
    repeat (2) @(negedge clk);
    ack_base = ack_seen;
    rst_n = 1'b1;
    for (int c = 0; c < 80 && (ack_seen - ack_base) < 4; c++) @(negedge clk);
    a_req[0] = 1'b0;
    b_req[0] = 1'b0;
    check("rr_ack_count", 32'(ack_seen - ack_base), 32'd4);
    check("rr_sb_empty", 32'(sb.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("rr_idle", 32'(busy[0]), 32'd0);

    // Reset during a write data phase aborts it and forgets the cached high byte.
    a_req[0] = 1'b1; a_we[0] = 1'b1; a_addr[0] = 16'h5678; a_wdata[0] = 8'hC3;
    @(posedge clk);
    repeat (3) @(negedge clk);
    check("abort_pre_we", 32'({pad_oe[0], pad_we[0]}), 32'd3);
    #2 rst_n = 1'b0;
    #1 check("abort_pads_released", 32'({pad_oe[0], pad_we[0], busy[0], a_ack[0]}), 32'd0);
    a_req[0] = 1'b0;
    reset_models();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_txn(0, 1'b0, 1'b1, 16'h5678, 8'hC3, 8'h00);
    check("post_abort_sb_empty", 32'(sb.size()), 32'd0);

    // Extreme wait-state builds.
    run_txn(1, 1'b0, 1'b1, 16'h0102, 8'h5A, 8'h00);
    run_txn(2, 1'b0, 1'b1, 16'h0102, 8'h5A, 8'h00);
    run_txn(2, 1'b0, 1'b0, 16'h0177, 8'h00, 8'h9E);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
